// File: rtl/ploc_gate_controller.sv
// Parking-lot entry gate and occupancy controller: counts entry/exit events from the
// sensor FSM, sequences the barrier (IDLE/OPEN/HOLD) and flags protocol errors.
module ploc_gate_controller #(
   parameter int CAPACITY       = 15,
   parameter int CNT_W          = 4,
   parameter int TIMEOUT_CYCLES = 32,
   parameter int HOLD_CYCLES    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       inc_dec,
   input  logic             req,
   output logic             gate_open,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             deny,
   output logic             err
);

   localparam int TMR_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {IDLE, OPEN, HOLD} state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic [1:0]         prev;
   logic [CNT_W-1:0]   count_nxt;
   logic               entry_evt, exit_evt;
   logic               cnt_err, seq_err, deny_nxt;

   // A code counts only on its first cycle after the sensor FSM returns to 00.
   assign entry_evt = (inc_dec == 2'b10) && (prev == 2'b00);
   assign exit_evt  = (inc_dec == 2'b01) && (prev == 2'b00);

   assign full  = (count == CNT_W'(CAPACITY));
   assign empty = (count == '0);

   always_comb begin
      count_nxt = count;
      cnt_err   = (inc_dec == 2'b11);
      if (entry_evt) begin
         if (count < CNT_W'(CAPACITY)) count_nxt = count + CNT_W'(1);
         else                          cnt_err   = 1'b1;
      end
      if (exit_evt) begin
         if (count != '0) count_nxt = count - CNT_W'(1);
         else             cnt_err   = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      deny_nxt  = 1'b0;
      seq_err   = 1'b0;
      case (state)
         IDLE: begin
            // Requests see the registered full flag, so an exit in the same cycle still denies.
            if (req && !full) begin
               state_nxt = OPEN;
               timer_nxt = TMR_W'(TIMEOUT_CYCLES - 1);
            end else if (req) begin
               deny_nxt = 1'b1;
            end
            if (entry_evt) seq_err = 1'b1;
         end
         OPEN: begin
            if (entry_evt) begin
               state_nxt = HOLD;
               timer_nxt = TMR_W'(HOLD_CYCLES - 1);
            end else if (timer == '0) begin
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         HOLD: begin
            if (timer == '0) state_nxt = IDLE;
            else             timer_nxt = timer - TMR_W'(1);
            if (entry_evt) seq_err = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         timer     <= '0;
         prev      <= 2'b00;
         count     <= '0;
         gate_open <= 1'b0;
         deny      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         prev      <= inc_dec;
         count     <= count_nxt;
         gate_open <= (state_nxt != IDLE);
         deny      <= deny_nxt;
         err       <= err | cnt_err | seq_err;
      end
   end

endmodule

// File: tb/tb_ploc_gate_controller.sv
// Bench for ploc_gate_controller: directed scenarios plus randomized traffic, all checked
// cycle by cycle against an occupancy / gate-time model.
module tb_ploc_gate_controller;

   localparam int CAP = 15;
   localparam int TO  = 32;
   localparam int HLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] inc_dec = 2'b00;
   logic       req = 1'b0;
   logic       gate_open, full, empty, deny, err;
   logic [3:0] count;

   int n_vec  = 0;
   int n_miss = 0;

   // Model state: occupancy, remaining open time and whether the gate still waits for a car.
   int         m_occ;
   int         m_left;
   bit         m_wait;
   bit         m_err;
   bit         m_deny;
   logic [1:0] m_prev;

   ploc_gate_controller #(
      .CAPACITY(CAP), .CNT_W(4), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HLD)
   ) dut (
      .clk(clk), .reset(rst_n), .inc_dec(inc_dec), .req(req),
      .gate_open(gate_open), .count(count), .full(full), .empty(empty),
      .deny(deny), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_occ = 0; m_left = 0; m_wait = 0; m_err = 0; m_deny = 0; m_prev = 2'b00;
   endtask

   task automatic model_edge(input bit r, input logic [1:0] c);
      bit ent, ext, was_full, closed;
      ent      = (c == 2'b10) && (m_prev == 2'b00);
      ext      = (c == 2'b01) && (m_prev == 2'b00);
      was_full = (m_occ == CAP);
      closed   = (m_left == 0);
      if (c == 2'b11) m_err = 1;
      if (ent) begin
         if (m_occ < CAP) m_occ++;
         else             m_err = 1;
      end
      if (ext) begin
         if (m_occ > 0) m_occ--;
         else           m_err = 1;
      end
      m_deny = closed && r && was_full;
      if (closed) begin
         if (ent) m_err = 1;
         if (r && !was_full) begin
            m_left = TO;
            m_wait = 1;
         end
      end else if (m_wait && ent) begin
         m_left = HLD;
         m_wait = 0;
      end else begin
         if (!m_wait && ent) m_err = 1;
         m_left--;
      end
      m_prev = c;
   endtask

   task automatic check_all();
      check_val("gate_open", gate_open, m_left > 0);
      check_val("count", count, m_occ);
      check_val("full", full, m_occ == CAP);
      check_val("empty", empty, m_occ == 0);
      check_val("deny", deny, m_deny);
      check_val("err", err, m_err);
   endtask

   task automatic step(input bit r, input logic [1:0] c);
      @(negedge clk);
      req = r;
      inc_dec = c;
      @(posedge clk);
      model_edge(r, c);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 2'b00);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = 1'b0;
      inc_dec = 2'b00;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Request, car arrives after two idle cycles, code returns to 00.
   task automatic enter_car();
      step(1, 2'b00);
      idle(2);
      step(0, 2'b10);
      step(0, 2'b00);
   endtask

   initial begin
      model_reset();
      apply_reset();

      // Basic entry
      step(1, 2'b00);
      check_val("basic_gate_up", gate_open, 1);
      idle(2);
      step(0, 2'b10);
      idle(HLD - 1);
      check_val("basic_gate_still_up", gate_open, 1);
      idle(1);
      check_val("basic_gate_down", gate_open, 0);
      check_val("basic_count", count, 1);
      check_val("basic_err", err, 0);

      // Timeout
      step(1, 2'b00);
      idle(TO - 1);
      check_val("timeout_still_up", gate_open, 1);
      idle(1);
      check_val("timeout_down", gate_open, 0);
      check_val("timeout_count", count, 1);

      // Fill to capacity
      apply_reset();
      for (int k = 0; k < CAP; k++) begin
         enter_car();
         idle(HLD);
      end
      check_val("fill_count", count, CAP);
      check_val("fill_full", full, 1);
      step(1, 2'b00);
      check_val("fill_deny", deny, 1);
      check_val("fill_gate_closed", gate_open, 0);
      step(0, 2'b00);
      check_val("fill_deny_pulse", deny, 0);
      // Exit coincident with a request while full still denies
      step(1, 2'b01);
      check_val("exit_req_deny", deny, 1);
      step(0, 2'b00);
      step(0, 2'b10);
      step(0, 2'b00);
      check_val("forced_count", count, CAP);
      check_val("forced_err", err, 1);

      // Exit underflow
      apply_reset();
      step(0, 2'b01);
      step(0, 2'b00);
      check_val("under_count", count, 0);
      check_val("under_empty", empty, 1);
      check_val("under_err", err, 1);

      // Held code counts once
      apply_reset();
      for (int i = 0; i < 5; i++) step(0, 2'b10);
      step(0, 2'b00);
      step(0, 2'b10);
      step(0, 2'b00);
      check_val("held_count", count, 2);
      apply_reset();
      step(0, 2'b11);
      step(0, 2'b00);
      check_val("illegal_err", err, 1);
      check_val("illegal_count", count, 0);

      // Mid-operation reset while in HOLD with three cars
      apply_reset();
      enter_car();
      idle(HLD);
      enter_car();
      idle(HLD);
      step(1, 2'b00);
      idle(2);
      step(0, 2'b10);
      check_val("mid_count3", count, 3);
      check_val("mid_in_hold", gate_open, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_gate_drop", gate_open, 0);
      check_val("mid_count_clr", count, 0);
      model_reset();
      inc_dec = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 2'b00);
      check_val("mid_reopen", gate_open, 1);

      // Randomized traffic against the model
      for (int rnd = 0; rnd < 20; rnd++) begin
         int ent_pct, ext_pct, bad_pct;
         ent_pct = 10 + (rnd % 4) * 8;
         ext_pct = 5 + (rnd % 3) * 5;
         bad_pct = (rnd % 5 == 4) ? 3 : 0;
         apply_reset();
         for (int cyc = 0; cyc < 150; cyc++) begin
            int p;
            logic [1:0] c;
            bit r;
            p = $urandom_range(0, 99);
            if (p < bad_pct)                          c = 2'b11;
            else if (p < bad_pct + ent_pct)           c = 2'b10;
            else if (p < bad_pct + ent_pct + ext_pct) c = 2'b01;
            else                                      c = 2'b00;
            r = ($urandom_range(0, 99) < 30);
            step(r, c);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ploc_gate_controller.md
# ploc_gate_controller

Entry-gate and occupancy controller for the parking lot. It consumes the `inc_dec` event code from the `PLOC_Machine` sensor FSM, keeps a saturating occupancy count, and sequences the entry barrier: it opens on a driver request when space is free, and closes after the car has passed or the request has timed out. It sits directly downstream of `PLOC_Machine` and drives the barrier actuator and the lot-status display.

## Interface
- `CAPACITY`, 15: number of spaces; `full` asserts at this count.
- `CNT_W`, 4: width of `count`; must satisfy 2^CNT_W − 1 ≥ CAPACITY.
- `TIMEOUT_CYCLES`, 32: maximum time the gate stays open waiting for an entry event.
- `HOLD_CYCLES`, 8: time the gate stays open after an entry event so the car clears the barrier.
- `clk`, input, 1: single clock; all logic updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `inc_dec`, input, 2: event code from the sensor FSM; 2'b10 = car entered, 2'b01 = car exited, 2'b00 = none, 2'b11 = illegal. Synchronous to `clk`.
- `req`, input, 1: entry request (ticket button), level, synchronous.
- `gate_open`, output, 1: barrier open command, registered.
- `count`, output, CNT_W: current occupancy, registered.
- `full`, output, 1: high when `count` == CAPACITY.
- `empty`, output, 1: high when `count` == 0.
- `deny`, output, 1: one-cycle pulse when a request is refused because the lot is full.
- `err`, output, 1: sticky error flag; cleared only by `reset`.

## Operation
- **Event detection.**
  - A register `prev` holds the last sampled `inc_dec`.
  - Entry event: `inc_dec`==2'b10 and `prev`==2'b00. Exit event: `inc_dec`==2'b01 and `prev`==2'b00.
  - An event code held for several cycles counts once. The upstream FSM must return to 2'b00 between events.
  - `inc_dec`==2'b11 sets `err` and is otherwise ignored.
- **Count.**
  - Entry event with `count` < CAPACITY: increment. With `count` == CAPACITY: hold the value and set `err`.
  - Exit event with `count` > 0: decrement. With `count` == 0: hold at 0 and set `err`.
  - The count updates in every FSM state, independent of the gate.
- **FSM states:** IDLE, OPEN, HOLD. A single down-counter `timer` serves both OPEN and HOLD.
  - IDLE: `gate_open`=0.
    - `req` and !`full`: go to OPEN, load `timer` = TIMEOUT_CYCLES−1.
    - `req` and `full`: pulse `deny`, stay in IDLE.
    - An entry event while in IDLE is a tailgate: it counts normally and sets `err`.
  - OPEN: `gate_open`=1.
    - Entry event: go to HOLD, load `timer` = HOLD_CYCLES−1.
    - Otherwise, when `timer`==0: go to IDLE (timeout).
    - Otherwise decrement `timer`.
    - `req` is ignored.
  - HOLD: `gate_open`=1.
    - When `timer`==0: go to IDLE. Otherwise decrement `timer`.
    - `req` is ignored. A second entry event counts and sets `err`.
- `deny` re-pulses every cycle `req` is held while the lot is full in IDLE.

## Timing
- **Reset values:** state=IDLE, `count`=0, `prev`=2'b00, `timer`=0, `gate_open`=0, `deny`=0, `err`=0, `empty`=1, `full`=0.
- **Count latency:** `count` changes on the first rising edge at which the event code is sampled with `prev`==00. `full` and `empty` follow in the same cycle, decoded from the `count` register.
- **Gate open:** `gate_open` rises on the edge that samples `req`=1 in IDLE (one-cycle latency).
- **Timeout:** with no entry event, `gate_open` stays high for exactly TIMEOUT_CYCLES cycles.
- **Hold:** after the entry-event edge, `gate_open` stays high for HOLD_CYCLES more cycles.
- **Deny:** `deny` is registered and high for exactly one cycle per refusing edge.
- **Reset mid-operation:** reset in OPEN or HOLD drops `gate_open` immediately (asynchronous) and clears the count to 0.
- **Simultaneous conditions:**
  - An entry event that brings the count to CAPACITY still moves OPEN → HOLD.
  - An exit event in the same cycle as a `req` while full: the request is evaluated against the pre-update `full`, so `deny` fires.

## Test plan
- **Basic entry:** reset, then `req`=1 for 1 cycle; `inc_dec`=10 three cycles later, then 00. Required: `gate_open`=1 one cycle after `req`; `count`=1; `gate_open` drops exactly HOLD_CYCLES=8 cycles after the event; `err`=0.
- **Timeout:** `req` pulse with no event. Required: `gate_open` high for 32 cycles, then IDLE; `count` unchanged.
- **Fill to capacity:** 15 request/entry sequences. Required: `count`=15 and `full`=1. A further `req` gives a 1-cycle `deny` and `gate_open` stays 0. A forced entry leaves `count`=15 and sets `err`=1.
- **Exit underflow:** from reset, `inc_dec`=01 then 00. Required: `count`=0, `empty`=1, `err`=1.
- **Held code:** `inc_dec`=10 held for 5 cycles, then 00, then 10 again. Required: `count` increments exactly twice. A value of 11 sets `err`.
- **Mid-operation reset:** drop `reset` while in HOLD with `count`=3. Required: `gate_open`=0 and `count`=0 immediately. After release, the block is in IDLE and accepts a new `req`.
